// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
// Read-domain consumer for an asynchronous FIFO. It pops DSIZE-bit words, packs PACK of them
// into one wide beat (lane 0 in the LSBs) and presents each beat on a valid/ready stream.
// A flush pulse forces a partial beat out, with m_keep marking the filled lanes.
//
// Ports:
//   rclk      read-domain clock, all state on rising edge
//   rrst      asynchronous active-high reset
//   rdata     FIFO read data, valid while rempty=0
//   rempty    FIFO empty flag
//   rinc      FIFO pop strobe (word on rdata consumed at this edge)
//   flush     single-cycle request to emit the partial accumulator
//   m_data    packed output beat, lane 0 in LSBs
//   m_keep    lane-valid mask for m_data
//   m_valid   output beat available
//   m_ready   downstream accept
//   busy      lanes held, flush pending, or beat waiting
//   beat_cnt  beats accepted downstream, wraps modulo 2^CNTW

module fifo_rd_packer #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned PACK  = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DSIZE-1:0]      rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  flush,
  output logic [PACK*DSIZE-1:0] m_data,
  output logic [PACK-1:0]       m_keep,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNTW-1:0]       beat_cnt
);

  localparam int unsigned CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] CntFull = CW'(PACK);

  logic [PACK-1:0][DSIZE-1:0] acc_q, acc_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       flush_pend_q, flush_pend_d;
  logic [PACK-1:0][DSIZE-1:0] m_data_q, m_data_d;
  logic [PACK-1:0]            m_keep_q, m_keep_d;
  logic                       m_valid_q, m_valid_d;
  logic [CNTW-1:0]            beat_cnt_q, beat_cnt_d;

  logic slot_free;
  logic xfer;
  logic accept;

  always_comb begin
    // Pops are gated by reset so the FIFO never loses a word while we are held in reset.
    rinc      = !rrst && !rempty && (cnt_q < CntFull) && !flush_pend_q;
    slot_free = !m_valid_q || m_ready;
    xfer      = slot_free && ((cnt_q == CntFull) || (flush_pend_q && (cnt_q != '0)));
    accept    = m_valid_q && m_ready;
    busy      = (cnt_q != '0) || flush_pend_q || m_valid_q;
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_valid_d    = m_valid_q;
    beat_cnt_d   = beat_cnt_q;

    // rinc and xfer are mutually exclusive: xfer needs a full accumulator or a pending flush,
    // both of which block popping.
    if (rinc) begin
      for (int unsigned i = 0; i < PACK; i++) begin
        if (cnt_q == CW'(i)) begin
          acc_d[i] = rdata;
        end
      end
      cnt_d = cnt_q + CW'(1);
    end

    if (xfer) begin
      // Lanes at or above cnt are stale leftovers from an earlier beat; zero them.
      for (int unsigned i = 0; i < PACK; i++) begin
        if (CW'(i) < cnt_q) begin
          m_data_d[i] = acc_q[i];
          m_keep_d[i] = 1'b1;
        end else begin
          m_data_d[i] = '0;
          m_keep_d[i] = 1'b0;
        end
      end
      m_valid_d    = 1'b1;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (accept) begin
        m_valid_d = 1'b0;
      end
      // A flush with nothing accumulated is dropped.
      if (flush && (cnt_q != '0)) begin
        flush_pend_d = 1'b1;
      end
    end

    if (accept) begin
      beat_cnt_d = beat_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_valid_q    <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_keep   = m_keep_q;
  assign m_valid  = m_valid_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a small array-based FIFO model feeds two DUT copies
// (default CNTW and CNTW=4) with identical stimulus; inputs are driven and outputs sampled
// on the falling clock edge.

module tb_fifo_rd_packer;

  logic        rclk;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic [15:0] beat_cnt;

  logic        w_rinc;
  logic [31:0] w_m_data;
  logic [3:0]  w_m_keep;
  logic        w_m_valid;
  logic        w_busy;
  logic [3:0]  w_beat_cnt;

  logic [7:0] mem [128];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       pop_err = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr[6:0]];

  always @(posedge rclk) begin
    if (rinc) begin
      if (rempty) pop_err <= 1'b1;
      rd_ptr <= rd_ptr + 1;
    end
  end

  fifo_rd_packer #(.DSIZE(8), .PACK(4), .CNTW(16)) u_dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (rinc),
    .flush    (flush),
    .m_data   (m_data),
    .m_keep   (m_keep),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  fifo_rd_packer #(.DSIZE(8), .PACK(4), .CNTW(4)) u_wrap (
    .rclk     (rclk),
    .rrst     (rrst),
    .rdata    (rdata),
    .rempty   (rempty),
    .rinc     (w_rinc),
    .flush    (flush),
    .m_data   (w_m_data),
    .m_keep   (w_m_keep),
    .m_valid  (w_m_valid),
    .m_ready  (m_ready),
    .busy     (w_busy),
    .beat_cnt (w_beat_cnt)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[6:0]] = b;
    wr_ptr++;
  endtask

  initial begin
    int          seen;
    logic [31:0] exp_word;

    rrst    = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    #2;
    chk("rst_hold_rinc", rinc, 0);
    chk("rst_hold_busy", busy, 0);
    tick(2);
    rrst = 1'b0;

    // Reset state
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_w_beat_cnt", w_beat_cnt, 0);
    chk("rst_busy", busy, 0);

    // Full beat, four pops then one idle transfer cycle
    m_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("full_rinc_pulse", rinc, 1);
      tick(1);
    end
    chk("full_idle_rinc", rinc, 0);
    chk("full_idle_valid", m_valid, 0);
    chk("full_idle_busy", busy, 1);
    tick(1);
    chk("full_valid", m_valid, 1);
    chk("full_data", m_data, 32'h04030201);
    chk("full_keep", m_keep, 4'b1111);
    chk("full_cnt_before_accept", beat_cnt, 0);
    tick(1);
    chk("full_valid_clr", m_valid, 0);
    chk("full_beat_cnt", beat_cnt, 1);
    chk("full_busy_clr", busy, 0);

    // Backpressure: first beat held while the second accumulator fills
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(6);
    chk("bp_hold_valid_a", m_valid, 1);
    chk("bp_hold_data_a", m_data, 32'h04030201);
    tick(6);
    chk("bp_hold_valid_b", m_valid, 1);
    chk("bp_hold_data_b", m_data, 32'h04030201);
    chk("bp_hold_keep_b", m_keep, 4'b1111);
    chk("bp_hold_beat_cnt", beat_cnt, 1);
    push(8'h09);
    #1;
    chk("bp_full_no_pop", rinc, 0);
    m_ready = 1'b1;
    tick(1);
    chk("bp_beat2_valid", m_valid, 1);
    chk("bp_beat2_data", m_data, 32'h08070605);
    chk("bp_beat_cnt_2", beat_cnt, 2);
    tick(1);
    chk("bp_drain_valid", m_valid, 0);
    chk("bp_beat_cnt_3", beat_cnt, 3);
    chk("bp_busy_lane", busy, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("bp_flush_wait", m_valid, 0);
    tick(1);
    chk("bp_flush_valid", m_valid, 1);
    chk("bp_flush_data", m_data, 32'h00000009);
    chk("bp_flush_keep", m_keep, 4'b0001);
    tick(1);
    chk("bp_flush_accept", beat_cnt, 4);
    chk("bp_flush_idle", busy, 0);

    // Partial flush with a word arriving while the flush is pending
    push(8'hAA); push(8'hBB);
    tick(2);
    chk("pf_busy", busy, 1);
    chk("pf_no_valid", m_valid, 0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    push(8'hCC);
    #1;
    chk("pf_pend_no_pop", rinc, 0);
    tick(1);
    chk("pf_valid", m_valid, 1);
    chk("pf_data", m_data, 32'h0000BBAA);
    chk("pf_keep", m_keep, 4'b0011);
    chk("pf_pop_after", rinc, 1);
    tick(1);
    chk("pf_accept", beat_cnt, 5);
    chk("pf_cc_busy", busy, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);
    chk("pf_cc_valid", m_valid, 1);
    chk("pf_cc_data", m_data, 32'h000000CC);
    chk("pf_cc_keep", m_keep, 4'b0001);
    tick(1);
    chk("pf_cc_accept", beat_cnt, 6);

    // Empty flush: nothing to send
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("ef_valid_a", m_valid, 0);
    chk("ef_busy_a", busy, 0);
    tick(2);
    chk("ef_valid_b", m_valid, 0);
    chk("ef_busy_b", busy, 0);

    // Eleven more beats: 17 in total, so the 4-bit counter wraps to 1
    for (int i = 0; i < 44; i++) push(8'(8'h10 + i));
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      tick(1);
      if (m_valid) begin
        for (int j = 0; j < 4; j++) exp_word[j*8 +: 8] = 8'(8'h10 + seen * 4 + j);
        chk("wrap_beat_data", m_data, exp_word);
        chk("wrap_beat_data_w", w_m_data, exp_word);
        seen++;
      end
    end
    chk("wrap_beats_seen", seen, 11);
    chk("wrap_beat_cnt16", beat_cnt, 17);
    chk("wrap_beat_cnt4", w_beat_cnt, 1);
    chk("wrap_idle", busy, 0);

    // Asynchronous reset mid-fill, between clock edges
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h21 + i));
    tick(10);
    chk("mr_pre_valid", m_valid, 1);
    chk("mr_pre_data", m_data, 32'h24232221);
    chk("mr_pre_busy", busy, 1);
    #2;
    rrst = 1'b1;
    push(8'h27);
    #1;
    chk("mr_valid", m_valid, 0);
    chk("mr_keep", m_keep, 0);
    chk("mr_data", m_data, 0);
    chk("mr_beat_cnt", beat_cnt, 0);
    chk("mr_w_beat_cnt", w_beat_cnt, 0);
    chk("mr_rinc", rinc, 0);
    chk("mr_busy", busy, 0);
    tick(1);
    rrst = 1'b0;
    tick(2);

    chk("no_pop_when_empty", pop_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-clock-domain consumer placed directly downstream of the asynchronous FIFO's read port.
- Pops DSIZE-bit words from the FIFO using its rdata/rempty/rinc interface.
- Packs PACK consecutive words into one wide beat and presents each beat on a valid/ready stream.
- A flush input forces a partial beat out, with byte-lane keep bits.

Parameters:
- DSIZE, 8, width of one FIFO word (one lane).
- PACK, 4, lanes per output beat (2..8).
- CNTW, 16, width of the emitted-beat counter.

Ports:
- rclk  input  1  read-domain clock; all state is updated on its rising edge.
- rrst  input  1  asynchronous, active-high reset.
- rdata  input  DSIZE  FIFO read data; valid whenever rempty=0.
- rempty  input  1  FIFO empty flag.
- rinc  output  1  FIFO pop strobe; the word on rdata is consumed at this rclk edge.
- flush  input  1  single-cycle request to emit the partial accumulator.
- m_data  output  PACK*DSIZE  packed beat; lane 0 is in the LSBs.
- m_keep  output  PACK  lane-valid mask for m_data.
- m_valid  output  1  beat available.
- m_ready  input  1  downstream accepts the beat when m_valid=1 and m_ready=1.
- busy  output  1  high when lane count cnt≠0, a flush is pending, or m_valid=1.
- beat_cnt  output  CNTW  number of beats accepted downstream; wraps modulo 2^CNTW.

Behaviour:
- Reset, applied asynchronously by rrst=1:
  - Cleared: accumulator, lane count cnt, flush_pend, m_data, m_keep, m_valid, beat_cnt.
  - rinc=0 and busy=0.
  - Reset mid-operation discards any words already popped into the accumulator. This loss is accepted; it is not an error.
- Internal state:
  - acc, PACK lanes.
  - cnt, range 0..PACK, width $clog2(PACK+1).
  - flush_pend, 1 bit.
  - Output register: m_data, m_keep, m_valid.
- Pop (combinational): rinc = !rempty && cnt<PACK && !flush_pend. rinc must never be asserted while rempty=1.
- On an edge with rinc=1:
  - acc lane[cnt] <= rdata.
  - cnt <= cnt+1.
  - Lane fill order is 0,1,...,PACK-1 (first word in the LSBs).
- Output slot free: slot_free = !m_valid || m_ready.
- Transfer event T = slot_free && (cnt==PACK || (flush_pend && cnt!=0)). On T:
  - m_data <= acc; unfilled lanes are zero.
  - m_keep <= (1<<cnt)-1.
  - m_valid <= 1.
  - cnt <= 0.
  - flush_pend <= 0.
- rinc and T are mutually exclusive:
  - T with cnt==PACK implies rinc=0 (cnt<PACK fails).
  - T with flush_pend=1 implies rinc=0.
- Output register, no T at this edge:
  - m_valid && m_ready clears m_valid.
  - m_data and m_keep hold.
  - While m_valid && !m_ready, m_data, m_keep and m_valid stay stable.
- beat_cnt increments on every edge with m_valid && m_ready, and wraps from all-ones to 0.
- Flush:
  - flush=1 sets flush_pend, unless the same edge clears it via T or the immediate-clear case below.
  - flush with cnt==0 and flush_pend=0: no beat is emitted and flush_pend stays 0.
  - flush while flush_pend=1: no extra effect.
  - While flush_pend=1, popping stops until the partial beat is transferred.
- Latency: the pop of the PACK-th word at edge k gives m_valid=1 after edge k+1, provided the slot is free.
- Throughput: PACK words per PACK+1 cycles at best, because the transfer cycle does not pop.
- Backpressure:
  - Full accumulator plus held output: rinc=0 until m_ready.
  - The FIFO then fills and its wfull throttles the writer.

Test Plan:
- Reset check: assert rrst mid-fill (cnt=2) -> m_valid=0, m_keep=0, beat_cnt=0, rinc=0 immediately, without waiting for an rclk edge.
- Full beat: FIFO holds 0x01,0x02,0x03,0x04, m_ready=1 -> four rinc pulses, then one idle pop cycle, then m_data=0x04030201, m_keep=4'b1111, beat_cnt=1.
- Backpressure: 8 bytes 0x01..0x08, m_ready=0 -> first beat 0x04030201 held stable; second accumulator fills; rinc=0 with rempty=0; m_ready=1 for 2 cycles -> beats 0x04030201 then 0x08070605, beat_cnt=2.
- Partial flush: bytes 0xAA,0xBB then flush pulse -> m_data=0x0000BBAA, m_keep=4'b0011; a third byte 0xCC arriving during flush_pend is not popped until after the transfer, then lands in lane 0.
- Empty flush: flush with cnt=0 -> no m_valid, busy stays 0.
- Counter wrap: CNTW=4, 17 beats accepted -> beat_cnt=1.
